serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing diff = a - b - bin over WIDTH cycles, LSB first, with borrow out. It is the subtract-direction counterpart of the team's parallel ripple-carry adder (a, b, carry-in → sum, carry-out). It trades the parallel adder's combinational chain for one full-subtractor cell, a borrow flop and a start/done handshake. Used where area matters more than latency.

Parameters:
WIDTH, 4, operand and result width in bits (≥2).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
start  input  1  request pulse; sampled only when the block is ready (IDLE or DONE).
a  input  WIDTH  minuend; sampled on the accepted start cycle only.
b  input  WIDTH  subtrahend; sampled on the accepted start cycle only.
bin  input  1  borrow in; sampled on the accepted start cycle only.
busy  output  1  high while an operation is in progress (RUN).
done  output  1  one-cycle pulse when diff/bout become valid.
diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH; held until the next completion.
bout  output  1  borrow out: 1 when a < b + bin (unsigned); held with diff.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state → IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: on start=1:
  - load a_sr←a, b_sr←b, brw←bin, cnt←0, r_sr←0; go to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ brw.
  - brw ← (~a_sr[0] & b_sr[0]) | (~a_sr[0] & brw) | (b_sr[0] & brw).
  - a_sr and b_sr shift right by 1.
  - r_sr ← {d, r_sr[WIDTH-1:1]}.
  - cnt ← cnt+1.
  - On the cycle with cnt == WIDTH-1: diff ← final r_sr value (including this cycle's d), bout ← final brw; go to DONE.
  - start is ignored in RUN; operands are not re-sampled.
- DONE: done=1 for exactly this one cycle. start=1 here is accepted exactly as in IDLE (back-to-back, next state RUN); otherwise go to IDLE.
- busy=1 exactly in RUN. Outputs are registered; no combinational path from inputs to outputs.
- Latency: start accepted at edge 0; busy high for WIDTH cycles; done high in cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- diff/bout change only on the RUN→DONE transition (or reset). They are stable from the done pulse until the next done.
- cnt width is $clog2(WIDTH); cnt wraps to 0 on entering RUN.
- Result must equal the combinational reference {bout, diff} = {1'b0, a} - {1'b0, b} - bin, with bout = MSB of that (WIDTH+1)-bit result.

Test Plan:
- Reset, then a=9, b=3, bin=0, start pulse → busy for 4 cycles; done at cycle 5; diff=6, bout=0.
- a=3, b=9, bin=0 → diff=0xA, bout=1. a=0, b=0, bin=1 → diff=0xF, bout=1. a=0xF, b=0xF, bin=0 → diff=0, bout=0.
- Hold start=1 continuously with changing a/b during RUN → operands re-sampled only in DONE. Back-to-back results 9-3=6 then 5-7=0xE (bout=1); no extra done pulses.
- Drop rst_n for one cycle at RUN cycle 2 → busy=0, diff=0, bout=0, no done. A subsequent 7-2 → diff=5 after the normal latency.
- Exhaustive sweep of all a, b, bin for WIDTH=4, plus 1000 random vectors at WIDTH=8, compared against the combinational reference. Check done fires exactly once per accepted start and diff is stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first over WIDTH cycles,
// one full-subtractor cell plus a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             d_c;
    logic             brw_c;
    logic [WIDTH-1:0] r_next_c;

    // Full-subtractor cell on the current LSBs.
    assign d_c      = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_c    = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & brw) | (b_sr[0] & brw);
    assign r_next_c = {d_c, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE for back-to-back use.
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        r_sr  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= brw_c;
                    r_sr <= r_next_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(LAST)) begin
                        diff  <= r_next_c;
                        bout  <= brw_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 directed + exhaustive, WIDTH=8 random,
// scoreboard queues checked on every done pulse, result stability checked between pulses.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    int tests  = 0;
    int errors = 0;
    int pushes4 = 0, dones4 = 0, pushes8 = 0, dones8 = 0;
    bit mon_en = 1'b0;
    logic rst_hit = 1'b0;
    logic [4:0] q4[$];
    logic [8:0] q8[$];
    logic [4:0] last4 = '0;
    logic [8:0] last8 = '0;

    function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - 5'(c);
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - 9'(c);
    endfunction

    always @(posedge clk) rst_hit <= !rst_n;

    // Scoreboard and hold checks for the 4-bit instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_hit) last4 = '0;
            if (done4 === 1'b1) begin
                dones4++;
                tests++;
                assert (q4.size() > 0) else begin
                    errors++; $error("FAIL done4_extra: observed done with empty queue, required none");
                end
                if (q4.size() > 0) begin
                    logic [4:0] e;
                    e = q4.pop_front();
                    tests++;
                    assert ({bout4, diff4} === e) else begin
                        errors++; $error("FAIL result4: observed %h required %h", {bout4, diff4}, e);
                    end
                end
                last4 = {bout4, diff4};
            end else begin
                tests++;
                assert ({bout4, diff4} === last4) else begin
                    errors++; $error("FAIL stable4: observed %h required %h", {bout4, diff4}, last4);
                end
            end
        end
    end

    // Scoreboard and hold checks for the 8-bit instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_hit) last8 = '0;
            if (done8 === 1'b1) begin
                dones8++;
                tests++;
                assert (q8.size() > 0) else begin
                    errors++; $error("FAIL done8_extra: observed done with empty queue, required none");
                end
                if (q8.size() > 0) begin
                    logic [8:0] e;
                    e = q8.pop_front();
                    tests++;
                    assert ({bout8, diff8} === e) else begin
                        errors++; $error("FAIL result8: observed %h required %h", {bout8, diff8}, e);
                    end
                end
                last8 = {bout8, diff8};
            end else begin
                tests++;
                assert ({bout8, diff8} === last8) else begin
                    errors++; $error("FAIL stable8: observed %h required %h", {bout8, diff8}, last8);
                end
            end
        end
    end

    // Waits (bounded) for done4; reports edges waited and busy cycles seen.
    task automatic wait_done4(output int n, output int nb);
        n = 0; nb = 0;
        while (done4 !== 1'b1 && n < 40) begin
            if (busy4 === 1'b1) nb++;
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (done4 === 1'b1) else begin
            errors++; $error("FAIL timeout4: observed done=%b required 1", done4);
        end
    endtask

    task automatic do4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int n, nb;
        a4 = x; b4 = y; bin4 = c; start4 = 1'b1;
        q4.push_back(ref4(x, y, c)); pushes4++;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done4(n, nb);
        tests++;
        assert (n == 4) else begin
            errors++; $error("FAIL latency4: observed %0d required 4", n);
        end
        tests++;
        assert (nb == 4) else begin
            errors++; $error("FAIL busy4: observed %0d required 4", nb);
        end
    endtask

    task automatic do8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n;
        a8 = x; b8 = y; bin8 = c; start8 = 1'b1;
        q8.push_back(ref8(x, y, c)); pushes8++;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (n == 8) else begin
            errors++; $error("FAIL latency8: observed %0d required 8", n);
        end
    endtask

    initial begin
        int n, nb;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        assert ({busy4, done4, bout4, diff4} === 7'b0) else begin
            errors++; $error("FAIL reset4: observed %b required 0", {busy4, done4, bout4, diff4});
        end
        tests++;
        assert ({busy8, done8, bout8, diff8} === 11'b0) else begin
            errors++; $error("FAIL reset8: observed %b required 0", {busy8, done8, bout8, diff8});
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed cases with spec-given constants.
        do4(4'd9, 4'd3, 1'b0);
        tests++;
        assert ({bout4, diff4} === 5'h06) else begin
            errors++; $error("FAIL sub_9_3: observed %h required 06", {bout4, diff4});
        end
        do4(4'd3, 4'd9, 1'b0);
        tests++;
        assert ({bout4, diff4} === 5'h1A) else begin
            errors++; $error("FAIL sub_3_9: observed %h required 1A", {bout4, diff4});
        end
        do4(4'd0, 4'd0, 1'b1);
        tests++;
        assert ({bout4, diff4} === 5'h1F) else begin
            errors++; $error("FAIL sub_0_0_1: observed %h required 1F", {bout4, diff4});
        end
        do4(4'hF, 4'hF, 1'b0);
        tests++;
        assert ({bout4, diff4} === 5'h00) else begin
            errors++; $error("FAIL sub_F_F: observed %h required 00", {bout4, diff4});
        end
        @(posedge clk); #1;

        // start held high; operands changing during RUN must be ignored.
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        q4.push_back(5'h06); pushes4++;
        @(posedge clk); #1;
        a4 = 4'd1; b4 = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        a4 = 4'd5; b4 = 4'd7;
        q4.push_back(5'h1E); pushes4++;
        wait_done4(n, nb);
        tests++;
        assert ({bout4, diff4} === 5'h06) else begin
            errors++; $error("FAIL hold_first: observed %h required 06", {bout4, diff4});
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done4(n, nb);
        tests++;
        assert ({bout4, diff4} === 5'h1E) else begin
            errors++; $error("FAIL hold_second: observed %h required 1E", {bout4, diff4});
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset during RUN aborts without a done pulse.
        a4 = 4'hC; b4 = 4'h1; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        assert ({busy4, done4, bout4, diff4} === 7'b0) else begin
            errors++; $error("FAIL abort: observed %b required 0", {busy4, done4, bout4, diff4});
        end
        repeat (6) @(posedge clk);
        #1;
        do4(4'd7, 4'd2, 1'b0);
        tests++;
        assert ({bout4, diff4} === 5'h05) else begin
            errors++; $error("FAIL after_abort: observed %h required 05", {bout4, diff4});
        end

        // Exhaustive WIDTH=4 sweep, back-to-back.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    do4(4'(i), 4'(j), 1'(k));
        repeat (3) @(posedge clk);
        #1;

        // Random WIDTH=8 vectors, back-to-back.
        for (int i = 0; i < 1000; i++)
            do8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        repeat (4) @(posedge clk);
        #1;

        tests++;
        assert (q4.size() == 0 && dones4 == pushes4) else begin
            errors++; $error("FAIL count4: observed dones %0d left %0d required %0d", dones4, q4.size(), pushes4);
        end
        tests++;
        assert (q8.size() == 0 && dones8 == pushes8) else begin
            errors++; $error("FAIL count8: observed dones %0d left %0d required %0d", dones8, q8.size(), pushes8);
        end
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
